uart_tx: RTL and testbench

- UART transmitter that serialises one parallel word per frame onto a single line.
- Runs in the oversampled clock domain: i_divided_clk = OSR x baud, and every bit is held for OSR enabled clocks.
- Framing and line polarity are identical to the team's UART receiver:
  - line idles low;
  - start bit(s) high;
  - data LSB first, uninverted;
  - stop bit(s) low.
- Sits between the CPU's output port / console logic and the physical TX pin.

---
 rtl/uart_tx.sv | 168 ++++++++++++++++
 tb/tb_uart_tx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter, oversampled bit clock domain.
// Frame: idle low, START high start bits, DATA bits LSB first, STOP low stop bits.
// Each bit is held for OSR enabled clocks.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx #(
  parameter int START = 1,
  parameter int DATA  = 8,
  parameter int STOP  = 2,
  parameter int OSR   = 16
) (
  input  logic            i_divided_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [DATA-1:0] i_data,
  input  logic            i_valid,
  output logic            o_ready,
  output logic            o_tx,
  output logic            o_done
);

  localparam int CNT_W = $clog2(OSR) + 1;
  localparam int IDX_W = $clog2(DATA) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OSR - 1);
  localparam logic [IDX_W-1:0] START_LAST = IDX_W'(START - 1);
  localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA - 1);
  localparam logic [IDX_W-1:0] STOP_LAST  = IDX_W'(STOP - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [DATA-1:0]  shift_reg;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  assign bit_end = (bit_cnt == CNT_LAST);

  // Frame sequencer: all state and the line itself are registered here so o_tx is glitch-free.
  always_ff @(posedge i_divided_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      o_tx       <= 1'b0;
      o_ready    <= 1'b1;
      o_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      if (i_en) begin
        case (state)
          S_IDLE: begin
            if (i_valid && o_ready) begin
              shift_reg  <= i_data;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^i_data;
`endif
              o_ready    <= 1'b0;
              o_tx       <= 1'b1;
              state      <= S_START;
              bit_cnt    <= '0;
              bit_idx    <= '0;
            end
          end

          S_START: begin
            if (bit_end) begin
              bit_cnt <= '0;
              if (bit_idx == START_LAST) begin
                state     <= S_DATA;
                bit_idx   <= '0;
                o_tx      <= shift_reg[0];
                shift_reg <= shift_reg >> 1;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          S_DATA: begin
            if (bit_end) begin
              bit_cnt <= '0;
              if (bit_idx == DATA_LAST) begin
                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                state   <= S_PARITY;
                o_tx    <= parity_bit;
`else
                state   <= S_STOP;
                o_tx    <= 1'b0;
`endif
              end else begin
                bit_idx   <= bit_idx + 1'b1;
                o_tx      <= shift_reg[0];
                shift_reg <= shift_reg >> 1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            if (bit_end) begin
              bit_cnt <= '0;
              bit_idx <= '0;
              state   <= S_STOP;
              o_tx    <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
`endif

          S_STOP: begin
            if (bit_end) begin
              bit_cnt <= '0;
              if (bit_idx == STOP_LAST) begin
                state   <= S_IDLE;
                bit_idx <= '0;
                o_ready <= 1'b1;
                o_done  <= 1'b1;
                o_tx    <= 1'b0;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          default: begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            o_ready <= 1'b1;
            o_tx    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with default parameters.
// Define UART_TX_PARITY_EN for both bench and design to exercise the parity build.
module tb_uart_tx;

  localparam int OSR = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 12;
`else
  localparam int FRAME_BITS = 11;
`endif
  localparam int FRAME_EN = FRAME_BITS * OSR;

  logic       clock;
  logic       reset;
  logic       en;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       done;

  int checks   = 0;
  int failures = 0;

  uart_tx #(.START(1), .DATA(8), .STOP(2), .OSR(OSR)) dut (
    .i_divided_clk (clock),
    .i_rst         (reset),
    .i_en          (en),
    .i_data        (data),
    .i_valid       (valid),
    .o_ready       (ready),
    .o_tx          (tx),
    .o_done        (done)
  );

  // Free-running oversampled clock, rising edges at 5, 15, 25 ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected line level after n enabled edges past the accepting edge.
  function automatic logic expTx(input logic [7:0] d, input int n);
    int b;
    b = n / OSR;
    if (b == 0) return 1'b1;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic e);
    valid = v;
    data  = d;
    en    = e;
  endtask

  // Accept one word, then follow the whole frame edge by edge.
  // toggle: i_en alternates 0/1 after accept. hold: leave i_valid high at the end.
  task automatic runFrame(input string label, input logic [7:0] d, input logic [7:0] junk,
                          input bit toggle, input bit hold);
    int  n;
    bit  enNow;
    applyStimulus(1'b1, d, 1'b1);
    @(posedge clock); #1;
    checkOutput({label, "_accept_ready"}, ready, 1'b0);
    checkOutput({label, "_accept_tx"}, tx, 1'b1);
    checkOutput({label, "_accept_done"}, done, 1'b0);
    n = 0;
    for (int cyc = 1; cyc <= 1000 && n < FRAME_EN; cyc++) begin
      enNow = toggle ? cyc[0] == 1'b0 : 1'b1;
      applyStimulus(hold, junk, enNow);
      @(posedge clock); #1;
      if (enNow) n++;
      checkOutput($sformatf("%s_tx_n%0d", label, n), tx,
                  (n < FRAME_EN) ? expTx(d, n) : 1'b0);
      checkOutput($sformatf("%s_done_n%0d", label, n), done, enNow && (n == FRAME_EN));
      checkOutput($sformatf("%s_ready_n%0d", label, n), ready, n == FRAME_EN);
    end
    checkOutput({label, "_frame_completed"}, n == FRAME_EN, 1'b1);
    if (!hold) begin
      applyStimulus(1'b0, junk, toggle ? 1'b0 : 1'b1);
      @(posedge clock); #1;
      checkOutput({label, "_post_done_clear"}, done, 1'b0);
      checkOutput({label, "_post_ready"}, ready, 1'b1);
      checkOutput({label, "_post_tx"}, tx, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    #1;
    checkOutput("reset_tx", tx, 1'b0);
    checkOutput("reset_ready", ready, 1'b1);
    checkOutput("reset_done", done, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Idle: line stays low and ready with no request.
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      checkOutput($sformatf("idle_tx_%0d", i), tx, 1'b0);
      checkOutput($sformatf("idle_ready_%0d", i), ready, 1'b1);
      checkOutput($sformatf("idle_done_%0d", i), done, 1'b0);
    end

    runFrame("a5", 8'hA5, 8'h5A, 1'b0, 1'b0);

    // Back-to-back with i_valid held: second accept lands on the very next edge.
    runFrame("b2b00", 8'h00, 8'hFF, 1'b0, 1'b1);
    runFrame("b2bff", 8'hFF, 8'h12, 1'b0, 1'b0);

    runFrame("en3c", 8'h3C, 8'hC3, 1'b1, 1'b0);

    // Abort a frame with reset mid-way, then send a fresh word.
    applyStimulus(1'b1, 8'hA5, 1'b1);
    @(posedge clock); #1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
    end
    checkOutput("abort_pre_tx", tx, expTx(8'hA5, 60));
    checkOutput("abort_pre_ready", ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_tx", tx, 1'b0);
    checkOutput("abort_ready", ready, 1'b1);
    checkOutput("abort_done", done, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("abort_idle_tx", tx, 1'b0);
    runFrame("r81", 8'h81, 8'h7E, 1'b0, 1'b0);

`ifdef UART_TX_PARITY_EN
    runFrame("par07", 8'h07, 8'hF0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
